i_fetch_unit: RTL

Instruction fetch stage directly upstream of `i_cache`. Holds the program counter and issues read-only requests on the cache CPU port. Holds each request until the cache reports a hit. Buffers returned instructions, tagged with their PC, in a small FIFO for the decode stage. Supports a single-cycle redirect (branch/jump) that flushes buffered and in-flight work.

---
 rtl/i_fetch_pkg.sv | 20 ++
 rtl/i_fetch_fifo.sv | 53 +++++
 rtl/i_fetch_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/i_fetch_pkg.sv
// rtl/i_fetch_pkg.sv - shared types and constants for the instruction fetch stage
package i_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  localparam int MISS_CNT_W = 16;
  localparam int FE_DATA_W  = 32;
  localparam int FE_ADD_W   = 12;

  // Buffered instruction as seen by decode: word plus the PC it was fetched from.
  typedef struct packed {
    logic [FE_DATA_W-1:0] data;
    logic [FE_ADD_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/i_fetch_fifo.sv
// rtl/i_fetch_fifo.sv - synchronous FIFO with flush, occupancy count and register-decoded head
module i_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 44,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Head is a mux of storage registers only, so no input reaches it combinationally.
  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/i_fetch_unit.sv
// rtl/i_fetch_unit.sv - PC sequencing, read-only cache requests and instruction buffering
module i_fetch_unit
  import i_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int RESET_PC   = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADD_WIDTH-1:0]  redirect_pc,
  output logic [ADD_WIDTH-1:0]  ic_add,
  output logic                  ic_ren,
  output logic                  ic_wen,
  output logic [DATA_WIDTH-1:0] ic_din,
  input  logic                  ic_hit_miss,
  input  logic [DATA_WIDTH-1:0] ic_q,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADD_WIDTH-1:0]  inst_pc,
  input  logic                  inst_ready,
  output logic [MISS_CNT_W-1:0] miss_count
);

  localparam int ENT_W = DATA_WIDTH + ADD_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADD_WIDTH-1:0] PC_RST = ADD_WIDTH'(RESET_PC);

  fetch_state_t       state;
  logic [ADD_WIDTH-1:0] pc;
  logic [ADD_WIDTH-1:0] pc_inc;
  logic                 miss_seen;
  logic                 pop_ok;
  logic                 hit;
  logic                 room_now;
  logic                 room_after_push;
  logic [CNT_W-1:0]     fifo_count;
  logic [CNT_W-1:0]     post_push_count;
  logic [ENT_W-1:0]     head_entry;

  assign ic_wen = 1'b0;
  assign ic_din = '0;

  assign pop_ok          = inst_valid & inst_ready;
  assign hit             = (state == WAIT) & ic_hit_miss;
  assign pc_inc          = pc + ADD_WIDTH'(1);
  assign post_push_count = fifo_count + CNT_W'(1) - CNT_W'(pop_ok);
  assign room_now        = fifo_count < CNT_W'(FIFO_DEPTH);
  assign room_after_push = post_push_count < CNT_W'(FIFO_DEPTH);

  i_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (redirect_valid),
    .push       (hit & ~redirect_valid),
    .push_data  ({ic_q, pc}),
    .pop        (inst_ready & ~redirect_valid),
    .head_valid (inst_valid),
    .head_data  (head_entry),
    .count      (fifo_count)
  );

  assign inst_data = head_entry[ENT_W-1:ADD_WIDTH];
  assign inst_pc   = head_entry[ADD_WIDTH-1:0];

  // REQ exists only to let the cache see the new address; its output that cycle is stale.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pc         <= PC_RST;
      ic_add     <= PC_RST;
      ic_ren     <= 1'b0;
      miss_seen  <= 1'b0;
      miss_count <= '0;
    end else if (redirect_valid) begin
      pc        <= redirect_pc;
      miss_seen <= 1'b0;
      if (fetch_en) begin
        state  <= REQ;
        ic_add <= redirect_pc;
        ic_ren <= 1'b1;
      end else begin
        state  <= IDLE;
        ic_ren <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (fetch_en && room_now) begin
            state  <= REQ;
            ic_add <= pc;
            ic_ren <= 1'b1;
          end
        end
        REQ: begin
          state     <= WAIT;
          miss_seen <= 1'b0;
        end
        WAIT: begin
          if (ic_hit_miss) begin
            pc <= pc_inc;
            if (fetch_en && room_after_push) begin
              state  <= REQ;
              ic_add <= pc_inc;
            end else begin
              state  <= IDLE;
              ic_ren <= 1'b0;
            end
          end else if (!miss_seen) begin
            miss_seen <= 1'b1;
            if (miss_count != '1) miss_count <= miss_count + MISS_CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          ic_ren <= 1'b0;
        end
      endcase
    end
  end

endmodule
